// File: rtl/iir_tdm_pkg.sv
// Shared types and width helpers for the time-multiplexed IIR filter.
package iir_tdm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_ROUND,
    ST_OUT
  } state_e;

  function automatic int unsigned iir_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic int unsigned iir_ch_width(input int unsigned ch);
    return (ch > 1) ? iir_clog2(ch) : 1;
  endfunction

  // Accumulator width: one full product, growth for every tap, plus a guard bit.
  function automatic int unsigned iir_acc_width(input int unsigned d, input int unsigned c,
                                                input int unsigned taps);
    return d + c + iir_clog2(taps) + 1;
  endfunction

endpackage

// File: rtl/iir_mac_sat.sv
// Signed multiply-accumulate with clear/enable, followed by round-half-up,
// arithmetic right shift and saturation into a registered output.
module iir_mac_sat
  import iir_tdm_pkg::*;
#(
  parameter int D_WIDTH     = 12,
  parameter int COEFF_WIDTH = 16,
  parameter int COEFF_FRAC  = 14,
  parameter int Y_WIDTH     = 12,
  parameter int ACC_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   en,
  input  logic                   sub,
  input  logic [D_WIDTH-1:0]     opd,
  input  logic [COEFF_WIDTH-1:0] coef,
  input  logic                   round_en,
  output logic [Y_WIDTH-1:0]     y,
  output logic                   sat
);

  localparam int PW = D_WIDTH + COEFF_WIDTH;
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (COEFF_FRAC - 1);

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_x;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] rnd;
  logic signed [ACC_W-1:0] shr;
  logic [ACC_W-Y_WIDTH:0]  hi;
  logic                    clip;

  assign prod   = $signed(opd) * $signed(coef);
  assign prod_x = ACC_W'(prod);

  // Accumulator: cleared at sample start, adds b-taps and subtracts a-taps.
  always_ff @(posedge clk) begin
    if (!rst_n)   acc_q <= '0;
    else if (clr) acc_q <= '0;
    else if (en)  acc_q <= sub ? (acc_q - prod_x) : (acc_q + prod_x);
  end

  // Rounding and overflow detection: clipped when the bits above the output sign differ.
  always_comb begin
    rnd  = acc_q + HALF;
    shr  = rnd >>> COEFF_FRAC;
    hi   = shr[ACC_W-1:Y_WIDTH-1];
    clip = !((&hi) || !(|hi));
  end

  // Output register: loaded once per sample, held through the output handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y   <= '0;
      sat <= 1'b0;
    end else if (round_en) begin
      sat <= clip;
      if (clip) y <= shr[ACC_W-1] ? {1'b1, {(Y_WIDTH-1){1'b0}}} : {1'b0, {(Y_WIDTH-1){1'b1}}};
      else      y <= shr[Y_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/iir_tdm.sv
// Multi-channel direct-form-I IIR filter sharing one multiplier across all taps
// and channels; runtime coefficient bank and per-channel x/y histories.
module iir_tdm
  import iir_tdm_pkg::*;
#(
  parameter int M           = 2,
  parameter int CHANNELS    = 2,
  parameter int X_WIDTH     = 12,
  parameter int Y_WIDTH     = 12,
  parameter int COEFF_WIDTH = 16,
  parameter int COEFF_FRAC  = 14
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [iir_ch_width(CHANNELS)-1:0]   s_chan,
  input  logic [X_WIDTH-1:0]                  s_data,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [iir_ch_width(CHANNELS)-1:0]   m_chan,
  output logic [Y_WIDTH-1:0]                  m_data,
  output logic                                m_sat,
  input  logic                                coef_we,
  output logic                                coef_ready,
  input  logic [iir_clog2(2*M+1)-1:0]         coef_addr,
  input  logic [COEFF_WIDTH-1:0]              coef_data
);

  localparam int unsigned TAPS     = 2 * M + 1;
  localparam int unsigned TAP_W    = iir_clog2(TAPS);
  localparam int unsigned CH_W     = iir_ch_width(CHANNELS);
  localparam int unsigned D_WIDTH  = (X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH;
  localparam int unsigned ACC_W    = iir_acc_width(D_WIDTH, COEFF_WIDTH, TAPS);
  localparam int unsigned TAP_LAST = TAPS - 1;
  localparam int unsigned A_FIRST  = M + 1;

  state_e                   state_q, state_d;
  logic [TAP_W-1:0]         tap_q;
  logic [CH_W-1:0]          ch_q;
  logic signed [X_WIDTH-1:0] x_q;
  logic signed [COEFF_WIDTH-1:0] coef_q [TAPS];
  logic signed [X_WIDTH-1:0] x_hist [CHANNELS][M];
  logic signed [Y_WIDTH-1:0] y_hist [CHANNELS][M];

  logic                     chan_ok;
  logic                     acc_clr, mac_en, round_en;
  logic signed [D_WIDTH-1:0] opd;
  logic                     sub;

  assign chan_ok = {1'b0, s_chan} < (CH_W + 1)'(CHANNELS);
  assign m_chan  = ch_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake/datapath strobes; out-of-range channels are accepted but never leave IDLE.
  always_comb begin
    state_d    = state_q;
    s_ready    = 1'b0;
    coef_ready = 1'b0;
    m_valid    = 1'b0;
    acc_clr    = 1'b0;
    mac_en     = 1'b0;
    round_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        s_ready    = 1'b1;
        coef_ready = 1'b1;
        if (s_valid && chan_ok) begin
          acc_clr = 1'b1;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        mac_en = 1'b1;
        if (tap_q == TAP_W'(TAP_LAST)) state_d = ST_ROUND;
      end
      ST_ROUND: begin
        round_en = 1'b1;
        state_d  = ST_OUT;
      end
      ST_OUT: begin
        m_valid = 1'b1;
        if (m_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand select: tap 0 is the new sample, then x history, then y history (subtracted).
  always_comb begin
    opd = D_WIDTH'(x_q);
    sub = 1'b0;
    for (int unsigned k = 0; k < M; k++) begin
      if (tap_q == TAP_W'(k + 1)) opd = D_WIDTH'(x_hist[ch_q][k]);
      if (tap_q == TAP_W'(A_FIRST + k)) begin
        opd = D_WIDTH'(y_hist[ch_q][k]);
        sub = 1'b1;
      end
    end
  end

  // Coefficient bank, sample capture, tap counter and history commit on the output handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tap_q <= '0;
      ch_q  <= '0;
      x_q   <= '0;
      for (int unsigned t = 0; t < TAPS; t++) coef_q[t] <= '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        for (int unsigned k = 0; k < M; k++) begin
          x_hist[c][k] <= '0;
          y_hist[c][k] <= '0;
        end
      end
    end else begin
      if (coef_we && coef_ready && (coef_addr <= TAP_W'(TAP_LAST)))
        coef_q[coef_addr] <= coef_data;
      if (acc_clr) begin
        ch_q  <= s_chan;
        x_q   <= s_data;
        tap_q <= '0;
      end else if (mac_en) begin
        tap_q <= tap_q + 1'b1;
      end
      if (m_valid && m_ready) begin
        for (int unsigned k = 1; k < M; k++) begin
          x_hist[ch_q][k] <= x_hist[ch_q][k-1];
          y_hist[ch_q][k] <= y_hist[ch_q][k-1];
        end
        x_hist[ch_q][0] <= x_q;
        y_hist[ch_q][0] <= m_data;
      end
    end
  end

  iir_mac_sat #(
    .D_WIDTH    (D_WIDTH),
    .COEFF_WIDTH(COEFF_WIDTH),
    .COEFF_FRAC (COEFF_FRAC),
    .Y_WIDTH    (Y_WIDTH),
    .ACC_W      (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (acc_clr),
    .en      (mac_en),
    .sub     (sub),
    .opd     (opd),
    .coef    (coef_q[tap_q]),
    .round_en(round_en),
    .y       (m_data),
    .sat     (m_sat)
  );

endmodule

// File: tb/tb_iir_tdm.sv
// Scoreboard bench for iir_tdm (M=2, 2 channels, 12-bit data, Q2.14 coefficients).
module tb_iir_tdm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, s_ready;
  logic [0:0]  s_chan;
  logic [11:0] s_data;
  logic        m_valid, m_ready;
  logic [0:0]  m_chan;
  logic [11:0] m_data;
  logic        m_sat;
  logic        coef_we, coef_ready;
  logic [2:0]  coef_addr;
  logic [15:0] coef_data;

  always #5 clk = ~clk;

  iir_tdm #(
    .M(2), .CHANNELS(2), .X_WIDTH(12), .Y_WIDTH(12), .COEFF_WIDTH(16), .COEFF_FRAC(14)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_chan(s_chan), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_chan(m_chan), .m_data(m_data), .m_sat(m_sat),
    .coef_we(coef_we), .coef_ready(coef_ready), .coef_addr(coef_addr), .coef_data(coef_data)
  );

  typedef struct { int chan; int data; int sat; } exp_t;
  exp_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cf[5];
  int xh[2][2];
  int yh[2][2];
  int last_data[2];
  int last_sat[2];

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) cf[i] = 0;
    for (int c = 0; c < 2; c++) begin
      xh[c][0] = 0; xh[c][1] = 0; yh[c][0] = 0; yh[c][1] = 0;
    end
  endtask

  // Reference filter: full-precision sum, round half up, floor shift, clip.
  task automatic model_push(input int ch, input int x);
    longint acc, r;
    exp_t e;
    acc = longint'(cf[0]) * x + longint'(cf[1]) * xh[ch][0] + longint'(cf[2]) * xh[ch][1]
        - longint'(cf[3]) * yh[ch][0] - longint'(cf[4]) * yh[ch][1];
    r = (acc + 8192) >>> 14;
    e.chan = ch;
    e.sat  = 0;
    if (r > 2047)       begin r = 2047;  e.sat = 1; end
    else if (r < -2048) begin r = -2048; e.sat = 1; end
    e.data = int'(r);
    xh[ch][1] = xh[ch][0]; xh[ch][0] = x;
    yh[ch][1] = yh[ch][0]; yh[ch][0] = e.data;
    sb_q.push_back(e);
  endtask

  // Output monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_out", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("out_chan", m_chan, e.chan);
        check("out_data", $signed(m_data), e.data);
        check("out_sat", m_sat, e.sat);
        last_data[m_chan] = $signed(m_data);
        last_sat[m_chan]  = m_sat;
      end
    end
  end

  task automatic wr_coef(input int addr, input int data);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = 3'(addr);
    coef_data = 16'(data);
    @(posedge clk);
    #1 coef_we = 1'b0;
    if (addr <= 4) cf[addr] = data;
  endtask

  // Sample send, optionally with a coefficient write in the same accept cycle.
  task automatic send_cw(input int ch, input int x, input bit we, input int addr, input int data);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("send_timeout", 0, 1);
    s_valid   = 1'b1;
    s_chan    = 1'(ch);
    s_data    = 12'(x);
    coef_we   = we;
    coef_addr = 3'(addr);
    coef_data = 16'(data);
    if (we && addr <= 4) cf[addr] = data;
    model_push(ch, x);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    coef_we = 1'b0;
  endtask

  task automatic send(input int ch, input int x);
    send_cw(ch, x, 1'b0, 0, 0);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sb_q.size() == 0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) check("drain_timeout", sb_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    int t2_exp[4];
    t2_exp = '{1024, 512, 256, 128};
    rst_n = 1'b0; s_valid = 1'b0; s_chan = '0; s_data = '0;
    m_ready = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_coef_ready", coef_ready, 1);
    check("rst_m_data", m_data, 0);
    check("rst_m_sat", m_sat, 0);
    check("rst_m_chan", m_chan, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Pass-through b0=1.0, latency measurement.
    wr_coef(0, 16384);
    send(0, 100);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_valid) break;
      @(posedge clk);
      lat++;
    end
    check("t1_latency", lat, 6);
    drain();
    check("t1_y0", last_data[0], 100);
    check("t1_sat0", last_sat[0], 0);
    send(0, 0); drain(); check("t1_y1", last_data[0], 0);
    send(0, 0); drain(); check("t1_y2", last_data[0], 0);

    // First-order feedback a1=-0.5.
    wr_coef(3, -8192);
    for (int i = 0; i < 4; i++) begin
      send(0, (i == 0) ? 1024 : 0);
      drain();
      check("t2_y", last_data[0], t2_exp[i]);
    end

    // Out-of-range address is ignored; coincident write lands before the sample.
    wr_coef(7, 12345);
    wr_coef(3, 0);
    send_cw(0, 100, 1'b1, 0, 32767);
    drain();
    check("t3_coincident", last_data[0], 200);
    send(0, 2047);  drain(); check("t3_pos_y", last_data[0], 2047);  check("t3_pos_sat", last_sat[0], 1);
    send(0, -2048); drain(); check("t3_neg_y", last_data[0], -2048); check("t3_neg_sat", last_sat[0], 1);
    send(0, 100);   drain(); check("t3_mid_y", last_data[0], 200);   check("t3_mid_sat", last_sat[0], 0);

    // Output stall: held outputs, no input/coef acceptance, single history advance.
    wr_coef(0, 16384); wr_coef(1, 16384); wr_coef(2, 16384);
    @(posedge clk);
    #1 m_ready = 1'b0;
    send(1, 10);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (m_valid) begin seen = 1'b1; break; end
      end
      check("t5_valid_seen", seen, 1);
    end
    for (int i = 0; i < 5; i++) begin
      check("t5_m_valid", m_valid, 1);
      check("t5_m_data", $signed(m_data), (sb_q.size() > 0) ? sb_q[0].data : 10);
      check("t5_s_ready", s_ready, 0);
      check("t5_coef_ready", coef_ready, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 m_ready = 1'b1;
    drain(); check("t5_y0", last_data[1], 10);
    send(1, 20); drain(); check("t5_y1", last_data[1], 30);
    send(1, 0);  drain(); check("t5_y2", last_data[1], 30);

    // Reset during MAC clears state, histories and coefficients.
    send(0, 500);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t6_m_valid", m_valid, 0);
    check("t6_s_ready", s_ready, 1);
    check("t6_coef_ready", coef_ready, 1);
    check("t6_m_data", m_data, 0);
    sb_q.delete();
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(0, 1024); drain(); check("t6_zero_coef", last_data[0], 0);

    // Interleaved channels with fresh histories.
    wr_coef(0, 16384);
    wr_coef(3, -8192);
    for (int i = 0; i < 4; i++) begin
      send(0, (i == 0) ? 1024 : 0);
      send(1, 0);
      drain();
      check("t4_ch0", last_data[0], t2_exp[i]);
      check("t4_ch1", last_data[1], 0);
    end

    repeat (5) @(posedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
